// File: rtl/vga_line_prefetch.sv
// Line prefetcher feeding the VGA output stage: keeps the displayed line and the next one
// resident in a two-bank line buffer, refilled word by word over the request handler bus.
module vga_line_prefetch #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LINES     = 96,
  parameter int          WORDS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  VGA_state,
  input  logic        data_en,
  input  logic [31:0] word_address_dest,
  output logic [31:0] SRAM_data_in,
  output logic        SRAM_busy,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] LAST_LINE_LIMIT = 8'(LINES);
  localparam logic [1:0] LAST_WORD       = 2'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t      state;
  logic [31:0] bank_data [2][4];
  logic [6:0]  bank_tag  [2];
  logic [1:0]  bank_valid;
  logic [7:0]  fetch_line;
  logic [1:0]  word_cnt;
  logic [7:0]  disp_line;
  logic        pending_start;
  logic [1:0]  prev_state;

  logic [8:0]  off;
  logic [6:0]  line;
  logic [1:0]  word;
  logic        rd_bank;
  logic        hit;
  logic        frame_start;
  logic [7:0]  fetch_limit;
  logic        can_fetch;

  function automatic logic [31:0] line_word_addr(input logic [6:0] l, input logic [1:0] w);
    return BASE_ADDR + {23'd0, l, w};
  endfunction

  assign off     = 9'(word_address_dest - BASE_ADDR);
  assign line    = off[8:2];
  assign word    = off[1:0];
  assign rd_bank = line[0];

  assign hit          = data_en & bank_valid[rd_bank] & (bank_tag[rd_bank] == line);
  assign SRAM_data_in = hit ? bank_data[rd_bank][word] : 32'd0;
  assign SRAM_busy    = data_en & ~hit;

  assign frame_start = (VGA_state == 2'd1) && (prev_state != 2'd1);

  // Before any line is displayed both banks are free, so lines 0 and 1 may be fetched;
  // afterwards stay one line ahead of the display so its bank is never overwritten.
  assign fetch_limit = (disp_line == 8'hFF) ? 8'd1 : disp_line + 8'd1;
  assign can_fetch   = (fetch_line < LAST_LINE_LIMIT) && (fetch_line <= fetch_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus_req       <= 1'b0;
      bus_addr      <= 32'd0;
      bus_sel       <= 4'h0;
      bank_valid    <= 2'b00;
      bank_tag[0]   <= 7'd0;
      bank_tag[1]   <= 7'd0;
      fetch_line    <= LAST_LINE_LIMIT;
      word_cnt      <= 2'd0;
      disp_line     <= 8'hFF;
      pending_start <= 1'b0;
      prev_state    <= 2'd0;
    end else begin
      prev_state <= VGA_state;
      if (data_en)
        disp_line <= {1'b0, line};
      if (frame_start)
        disp_line <= 8'hFF;

      case (state)
        IDLE: begin
          if (pending_start) begin
            bank_valid    <= 2'b00;
            fetch_line    <= 8'd0;
            pending_start <= 1'b0;
          end else if (can_fetch) begin
            bank_valid[fetch_line[0]] <= 1'b0;
            word_cnt <= 2'd0;
            bus_req  <= 1'b1;
            bus_sel  <= 4'hF;
            bus_addr <= line_word_addr(fetch_line[6:0], 2'd0);
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            // A new frame abandons the partly filled line; its bank stays invalid.
            if (pending_start || frame_start) begin
              bus_req <= 1'b0;
              bus_sel <= 4'h0;
              state   <= IDLE;
            end else begin
              bank_data[fetch_line[0]][word_cnt] <= bus_rdata;
              if (word_cnt == LAST_WORD) begin
                bus_req <= 1'b0;
                bus_sel <= 4'h0;
                state   <= FILL;
              end else begin
                word_cnt <= word_cnt + 2'd1;
                bus_addr <= line_word_addr(fetch_line[6:0], word_cnt + 2'd1);
              end
            end
          end
        end
        FILL: begin
          bank_tag[fetch_line[0]]   <= fetch_line[6:0];
          bank_valid[fetch_line[0]] <= 1'b1;
          fetch_line <= fetch_line + 8'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (frame_start)
        pending_start <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Randomized bench for vga_line_prefetch: a line-residency model predicts lookups and the
// exact sequence of fetch addresses, which a bus responder checks as it acknowledges them.
module tb_vga_line_prefetch;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          LINES = 96;

  logic        clk;
  logic        rst;
  logic [1:0]  VGA_state;
  logic        data_en;
  logic [31:0] word_address_dest;
  logic [31:0] SRAM_data_in;
  logic        SRAM_busy;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  vga_line_prefetch #(.BASE_ADDR(BASE), .LINES(LINES), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .VGA_state(VGA_state), .data_en(data_en),
    .word_address_dest(word_address_dest), .SRAM_data_in(SRAM_data_in),
    .SRAM_busy(SRAM_busy), .bus_req(bus_req), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [512];
  int          num_checks;
  int          num_fails;
  int          res_line [2];
  int          next_fetch;
  logic [31:0] exp_q [$];
  logic [31:0] last_ack_addr;
  bit          ack_en;
  int          ack_pct;
  bit          force_ack;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: a line is resident in bank line%2 once fetched; fetching runs ahead to
  // one line past the displayed one, or lines 0 and 1 at frame start, never past LINES-1.
  task automatic model_fetch_upto(input int limit);
    while (next_fetch < LINES && next_fetch <= limit) begin
      for (int w = 0; w < 4; w++)
        exp_q.push_back(BASE + 32'(next_fetch * 4 + w));
      res_line[next_fetch % 2] = next_fetch;
      next_fetch++;
    end
  endtask

  // Memory/request handler: acknowledges with random delay and checks each completed address.
  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (force_ack) begin
      bus_ack = 1'b1;
    end else if (!rst && bus_req && ack_en && ($urandom_range(0, 99) < ack_pct)) begin
      bus_ack       = 1'b1;
      bus_rdata     = mem[bus_addr[8:0]];
      last_ack_addr = bus_addr;
      checkOutput("bus_sel", 32'(bus_sel), 32'hF);
      if (exp_q.size() == 0)
        checkOutput("unexpected_req_addr", bus_addr, 32'hFFFF_FFFF);
      else
        checkOutput("bus_addr", bus_addr, exp_q.pop_front());
    end
  end

  task automatic waitIdle();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (!bus_req) quiet++;
      else quiet = 0;
    end
    checkOutput("idle_timeout", 32'(quiet), 32'd4);
    checkOutput("fetches_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic frameStart();
    @(negedge clk);
    VGA_state = 2'd1;
    res_line[0] = -1;
    res_line[1] = -1;
    next_fetch  = 0;
    model_fetch_upto(1);
    @(negedge clk);
    VGA_state = 2'd2;
  endtask

  task automatic applyStimulus(input int line, input int word);
    bit hit;
    @(negedge clk);
    data_en = 1'b1;
    word_address_dest = BASE + 32'(line * 4 + word);
    #1;
    hit = (res_line[line % 2] == line);
    if (hit) begin
      checkOutput("hit_busy", 32'(SRAM_busy), 32'd0);
      checkOutput("hit_data", SRAM_data_in, mem[line * 4 + word]);
    end else begin
      checkOutput("miss_busy", 32'(SRAM_busy), 32'd1);
      checkOutput("miss_data", SRAM_data_in, 32'd0);
    end
    @(negedge clk);
    data_en = 1'b0;
    word_address_dest = $urandom;
    #1;
    checkOutput("noen_busy", 32'(SRAM_busy), 32'd0);
    checkOutput("noen_data", SRAM_data_in, 32'd0);
    model_fetch_upto(line + 1);
  endtask

  task automatic checkNoRequest(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus_req) seen++;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    res_line[0] = -1;
    res_line[1] = -1;
    next_fetch  = LINES;
    last_ack_addr = 32'd0;
    ack_en = 1'b0; ack_pct = 100; force_ack = 1'b0;
    rst = 1'b1; VGA_state = 2'd0; data_en = 1'b0; word_address_dest = 32'd0;

    repeat (2) @(negedge clk);
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_sel", 32'(bus_sel), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    data_en = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(SRAM_busy), 32'd1);
    checkOutput("rst_data", SRAM_data_in, 32'd0);
    data_en = 1'b0;
    rst = 1'b0;
    checkNoRequest("no_req_before_frame", 12);

    // Frame start with an always-acking bus: lines 0 and 1 only.
    ack_en = 1'b1;
    frameStart();
    waitIdle();

    // Read line 1 with the bus stalled: hit, then line 2 fetch request appears.
    ack_en = 1'b0;
    applyStimulus(1, 1);
    for (int i = 0; i < 6 && !bus_req; i++) @(negedge clk);
    checkOutput("line2_req", 32'(bus_req), 32'd1);
    checkOutput("line2_addr", bus_addr, BASE + 32'd8);
    applyStimulus(3, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("stall_req", 32'(bus_req), 32'd1);
      checkOutput("stall_addr", bus_addr, BASE + 32'd8);
      checkOutput("stall_sel", 32'(bus_sel), 32'hF);
    end
    ack_en = 1'b1;
    ack_pct = 60;
    waitIdle();

    // Random frames with occasional jumps; the last frame reads every line in order.
    for (int f = 0; f < 3; f++) begin
      if (f == 2) ack_pct = 100;
      frameStart();
      waitIdle();
      for (int cur = 0; cur < LINES; cur++) begin
        int reads = $urandom_range(1, 3);
        for (int r = 0; r < reads; r++) begin
          if (f < 2 && $urandom_range(0, 19) == 0)
            applyStimulus($urandom_range(0, 127), $urandom_range(0, 3));
          else
            applyStimulus(cur, $urandom_range(0, 3));
          waitIdle();
        end
      end
    end
    checkOutput("last_fetch_addr", last_ack_addr, BASE + 32'd383);
    checkNoRequest("no_req_after_last", 20);

    // Reset in the middle of a stalled request.
    ack_en = 1'b0;
    frameStart();
    for (int i = 0; i < 10 && !bus_req; i++) @(negedge clk);
    checkOutput("pre_rst_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    VGA_state = 2'd0;
    @(negedge clk);
    checkOutput("mid_rst_req", 32'(bus_req), 32'd0);
    checkOutput("mid_rst_sel", 32'(bus_sel), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    res_line[0] = -1;
    res_line[1] = -1;
    next_fetch  = LINES;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    checkNoRequest("no_req_after_rst", 10);
    applyStimulus(0, 0);
    applyStimulus(1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d failures so far", num_fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
